pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC width in bits.
REQ-002 SHALL have parameter OFFSET_W, default 8: signed word-offset width.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, at least 2.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port STALL  input  1  memory busywait; freezes all state.
REQ-007 SHALL have port SEL_offset  input  2  flow select: 00 seq, 01 jump, 10 beq, 11 bne.
REQ-008 SHALL have port ZERO  input  1  ALU zero flag.
REQ-009 SHALL have port OFFSET  input  OFFSET_W  signed word offset.
REQ-010 SHALL have port CALL  input  1  push return address and jump.
REQ-011 SHALL have port RET  input  1  pop return address into PC.
REQ-012 SHALL have port PC  output  ADDR_W  registered program counter.
REQ-013 SHALL have port PC_NEXT  output  ADDR_W  combinational next-PC.
REQ-014 SHALL have port RAS_FULL  output  1  stack holds RAS_DEPTH entries.
REQ-015 SHALL have port RAS_EMPTY  output  1  stack holds zero entries.
REQ-016 SHALL have port RAS_ERR  output  1  one-cycle pulse on overflow, underflow or CALL+RET conflict.

Function
REQ-017 SHALL compute SEQ = PC+4 and TARGET = SEQ + (sign-extended OFFSET << 2), both modulo 2^ADDR_W.
REQ-018 SHALL select PC_NEXT by priority: RET, then CALL, then SEL_offset.
- RET: stack top.
- CALL: TARGET.
- SEL_offset 01: TARGET.
- SEL_offset 10: TARGET if ZERO, else SEQ.
- SEL_offset 11: TARGET if !ZERO, else SEQ.
- SEL_offset 00: SEQ.
REQ-019 SHALL load PC <= PC_NEXT on each rising edge with RESET=0 and STALL=0, giving one-cycle latency.
REQ-020 SHALL hold PC, stack contents, pointer and count unchanged while STALL=1, and SHALL hold RAS_ERR at 0 during a stall.
REQ-021 CALL SHALL push SEQ onto the stack in the same edge that PC loads TARGET.
REQ-022 RET on a non-empty stack SHALL pop the top entry into PC.
REQ-023 CALL when full SHALL overwrite the oldest entry (circular), keep the count at RAS_DEPTH, and pulse RAS_ERR.
REQ-024 RET when empty SHALL load SEQ, leave the stack unchanged, and pulse RAS_ERR.
REQ-025 CALL and RET together SHALL perform RET only and pulse RAS_ERR.
REQ-026 The stack pointer SHALL wrap modulo RAS_DEPTH.
REQ-027 The stack count SHALL saturate at 0 and RAS_DEPTH.
REQ-028 RAS_FULL and RAS_EMPTY SHALL be decoded from the registered count.

Reset
REQ-029 RESET=1 at an edge SHALL set PC=0, count=0, pointer=0 and RAS_ERR=0, giving RAS_EMPTY=1 and RAS_FULL=0.
REQ-030 RESET SHALL take priority over STALL, CALL and RET, including mid-stall and mid-call sequence.
REQ-031 Stack entry contents need not be cleared on reset.

Configuration
REQ-032 Macro PC_SEQ_RAS_EN defined: the return-address stack SHALL be fully implemented as specified above.
REQ-033 Macro PC_SEQ_RAS_EN undefined:
- no stack storage SHALL be implemented;
- CALL and RET SHALL be ignored;
- RAS_FULL SHALL be tied to 0, RAS_EMPTY to 1 and RAS_ERR to 0.

Structure
REQ-034 Package pc_seq_pkg SHALL hold:
- SEL_offset encodings SEL_SEQ, SEL_JUMP, SEL_BEQ and SEL_BNE;
- constant PC_INCR=4;
- constant WORD_SHIFT=2.
REQ-035 The stack SHALL be sub-module ras_stack, with push, pop, top, full, empty and err ports, parametrised by ADDR_W and RAS_DEPTH.

Verification (ADDR_W=32, OFFSET_W=8, RAS_DEPTH=4)
REQ-036 Scenario: reset, then 3 cycles at SEL_offset=00 -> PC sequence 0, 4, 8, 12.
REQ-037 Scenario: PC=8, SEL_offset=10, OFFSET=8'hFE.
- ZERO=1 -> next PC 0x4.
- ZERO=0 -> next PC 0xC.
- With SEL_offset=11 the taken and not-taken outcomes swap.
REQ-038 Scenario: PC=0x10, CALL, OFFSET=4 -> PC=0x24, top=0x14, RAS_EMPTY=0; then RET -> PC=0x14, RAS_EMPTY=1.
- CALL and RET together on an empty stack -> PC=SEQ, RAS_ERR pulse.
REQ-039 Scenario: 5 CALLs.
- RAS_FULL=1 after the 4th CALL.
- The 5th CALL pulses RAS_ERR.
- 4 RETs return addresses of CALLs 5, 4, 3, 2.
- A 5th RET pulses RAS_ERR and loads SEQ.
REQ-040 Scenario: STALL=1 for 3 cycles with SEL_offset=01 -> PC and count unchanged; RESET asserted during the stall -> PC=0 next edge.
REQ-041 Scenario: PC_SEQ_RAS_EN undefined, CALL at PC=0x10 -> PC=0x14 and RAS_EMPTY stays 1.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: flow-select encodings and
// address arithmetic constants.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'b00,
    SEL_JUMP = 2'b01,
    SEL_BEQ  = 2'b10,
    SEL_BNE  = 2'b11
  } sel_e;

  // Byte increment between sequential instructions.
  localparam int unsigned PC_INCR    = 4;
  // Word offsets are scaled to bytes by this shift.
  localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry. A pop when empty leaves the stack untouched. Push and pop together
// behave as a pop. Each of those three cases raises o_err for one cycle.
// A stall freezes all state and forces o_err low.
module ras_stack #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_err
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;  // next free slot; the top entry sits at r_ptr-1
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic              w_do_push;
  logic              w_do_pop;
  logic              w_err;
  logic [PTR_W-1:0]  w_top_idx;

  assign o_full    = (r_cnt == CNT_W'(RAS_DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_err     = r_err;

  // A pop wins over a simultaneous push.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && !i_pop;
  assign w_err     = (i_push && i_pop) || (i_pop && o_empty) || (w_do_push && o_full);

  // Entry storage: written on an accepted push and never cleared.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_stall && w_do_push) begin
      r_mem[r_ptr] <= i_data;
    end
  end

  // Pointer, occupancy and error pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_stall) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_do_pop) begin
        r_ptr <= r_ptr - PTR_W'(1);
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (w_do_push) begin
        r_ptr <= r_ptr + PTR_W'(1);
        if (!o_full) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch/jump select and an optional
// return-address stack. The stack exists only when PC_SEQ_RAS_EN is defined.
// Otherwise CALL and RET are ignored and the stack status outputs are tied
// off.
module pc_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned OFFSET_W  = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                STALL,
  input  logic [1:0]          SEL_offset,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET,
  input  logic                CALL,
  input  logic                RET,
  output logic [ADDR_W-1:0]   PC,
  output logic [ADDR_W-1:0]   PC_NEXT,
  output logic                RAS_FULL,
  output logic                RAS_EMPTY,
  output logic                RAS_ERR
);

  import pc_seq_pkg::*;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_off_ext;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_flow;

  assign w_seq     = r_pc + ADDR_W'(PC_INCR);
  assign w_off_ext = ADDR_W'($signed(OFFSET));
  assign w_target  = w_seq + (w_off_ext << WORD_SHIFT);
  assign PC        = r_pc;

  // Flow selection from SEL_offset and the ALU zero flag.
  always_comb begin
    w_flow = w_seq;
    unique case (sel_e'(SEL_offset))
      SEL_SEQ:  w_flow = w_seq;
      SEL_JUMP: w_flow = w_target;
      SEL_BEQ:  w_flow = ZERO ? w_target : w_seq;
      SEL_BNE:  w_flow = ZERO ? w_seq : w_target;
      default:  w_flow = w_seq;
    endcase
  end

`ifdef PC_SEQ_RAS_EN
  logic [ADDR_W-1:0] w_top;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_stall (STALL),
    .i_push  (CALL),
    .i_pop   (RET),
    .i_data  (w_seq),
    .o_top   (w_top),
    .o_full  (RAS_FULL),
    .o_empty (RAS_EMPTY),
    .o_err   (RAS_ERR)
  );

  // Next-PC priority: RET, then CALL, then the flow select.
  always_comb begin
    PC_NEXT = w_flow;
    if (RET) begin
      PC_NEXT = RAS_EMPTY ? w_seq : w_top;
    end else if (CALL) begin
      PC_NEXT = w_target;
    end
  end
`else
  logic w_unused_ras;

  assign w_unused_ras = ^{CALL, RET, RAS_DEPTH[0]};
  assign RAS_FULL     = 1'b0;
  assign RAS_EMPTY    = 1'b1;
  assign RAS_ERR      = 1'b0;

  // Without the stack only the flow select steers the PC.
  always_comb begin
    PC_NEXT = w_flow;
  end
`endif

  // Program counter register; reset overrides stall.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc <= '0;
    end else if (!STALL) begin
      r_pc <= PC_NEXT;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (ADDR_W=32, OFFSET_W=8, RAS_DEPTH=4).
// A queue-based model tracks PC and the return stack and is compared against
// the DUT on every falling edge. Directed scenarios add literal expectations.
// Follows PC_SEQ_RAS_EN the same way the design does.
module tb_pc_sequencer;

  import pc_seq_pkg::*;

`ifdef PC_SEQ_RAS_EN
  localparam bit RasOn = 1'b1;
`else
  localparam bit RasOn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic [1:0]  SEL_offset = 2'b00;
  logic        ZERO = 1'b0;
  logic [7:0]  OFFSET = 8'h00;
  logic        CALL = 1'b0;
  logic        RET = 1'b0;
  logic [31:0] PC;
  logic [31:0] PC_NEXT;
  logic        RAS_FULL;
  logic        RAS_EMPTY;
  logic        RAS_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(
    .ADDR_W    (32),
    .OFFSET_W  (8),
    .RAS_DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .STALL      (STALL),
    .SEL_offset (SEL_offset),
    .ZERO       (ZERO),
    .OFFSET     (OFFSET),
    .CALL       (CALL),
    .RET        (RET),
    .PC         (PC),
    .PC_NEXT    (PC_NEXT),
    .RAS_FULL   (RAS_FULL),
    .RAS_EMPTY  (RAS_EMPTY),
    .RAS_ERR    (RAS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc = '0;
  logic [31:0] m_stack[$];
  bit          m_err = 1'b0;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] m_next();
    logic [31:0] seq;
    logic [31:0] tgt;
    int          off;
    bit          taken;
    seq   = m_pc + 32'd4;
    off   = $signed(OFFSET);
    tgt   = seq + 32'(off * 4);
    taken = (SEL_offset == 2'd1) || (SEL_offset == 2'd2 && ZERO) ||
            (SEL_offset == 2'd3 && !ZERO);
    if (RasOn && RET) return (m_stack.size() > 0) ? m_stack[$] : seq;
    if (RasOn && CALL) return tgt;
    return taken ? tgt : seq;
  endfunction

  always @(posedge CLK) begin
    logic [31:0] nxt;
    if (RESET) begin
      m_pc = '0;
      m_stack.delete();
      m_err = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (STALL) begin
        m_err = 1'b0;
      end else begin
        nxt = m_next();
        m_err = 1'b0;
        if (RasOn) begin
          if (RET) begin
            if (CALL || m_stack.size() == 0) m_err = 1'b1;
            if (m_stack.size() > 0) void'(m_stack.pop_back());
          end else if (CALL) begin
            if (m_stack.size() == 4) begin
              m_err = 1'b1;
              void'(m_stack.pop_front());
            end
            m_stack.push_back(m_pc + 32'd4);
          end
        end
        m_pc = nxt;
      end
    end
  end

  // Compare process: every falling edge once the model is initialised.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("pc", PC, m_pc);
      check("pc_next", PC_NEXT, m_next());
      check("ras_full", {31'd0, RAS_FULL}, {31'd0, m_stack.size() == 4});
      check("ras_empty", {31'd0, RAS_EMPTY}, {31'd0, m_stack.size() == 0});
      check("ras_err", {31'd0, RAS_ERR}, {31'd0, m_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic rst, input logic stl, input logic [1:0] sel,
                       input logic z, input logic [7:0] off, input logic c, input logic r);
    @(posedge CLK);
    #1;
    RESET = rst; STALL = stl; SEL_offset = sel; ZERO = z; OFFSET = off; CALL = c; RET = r;
  endtask

  task automatic seq_cycle();
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, SEL_SEQ, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, then sequential fetch: 0, 4, 8, 12.
    do_reset();
    seq_cycle(); #1;
    check("lit_rst_pc", PC, 32'h0);
    check("lit_rst_empty", {31'd0, RAS_EMPTY}, 32'd1);
    check("lit_rst_full", {31'd0, RAS_FULL}, 32'd0);
    check("lit_rst_err", {31'd0, RAS_ERR}, 32'd0);
    seq_cycle(); #1; check("lit_seq_4", PC, 32'h4);
    seq_cycle(); #1; check("lit_seq_8", PC, 32'h8);
    seq_cycle(); #1; check("lit_seq_c", PC, 32'hC);

    // Conditional branches at PC=8 with offset -2 words.
    do_reset();
    seq_cycle();
    seq_cycle();
    apply(1'b0, 1'b0, SEL_BEQ, 1'b1, 8'hFE, 1'b0, 1'b0); #1;
    check("lit_br_pc", PC, 32'h8);
    check("lit_beq_taken", PC_NEXT, 32'h4);
    ZERO = 1'b0; #1;
    check("lit_beq_not", PC_NEXT, 32'hC);
    SEL_offset = SEL_BNE; #1;
    check("lit_bne_taken", PC_NEXT, 32'h4);
    ZERO = 1'b1; #1;
    check("lit_bne_not", PC_NEXT, 32'hC);
    ZERO = 1'b0;
    seq_cycle(); #1;
    check("lit_bne_pc", PC, 32'h4);

    // CALL at PC=0x10 with offset 4, then RET, then CALL+RET on empty.
    do_reset();
    repeat (4) seq_cycle();
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h04, 1'b1, 1'b0); #1;
    check("lit_call_at", PC, 32'h10);
`ifdef PC_SEQ_RAS_EN
    check("lit_call_next", PC_NEXT, 32'h24);
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h04, 1'b0, 1'b1); #1;
    check("lit_call_pc", PC, 32'h24);
    check("lit_call_empty", {31'd0, RAS_EMPTY}, 32'd0);
    check("lit_call_top", PC_NEXT, 32'h14);
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h04, 1'b1, 1'b1); #1;
    check("lit_ret_pc", PC, 32'h14);
    check("lit_ret_empty", {31'd0, RAS_EMPTY}, 32'd1);
    check("lit_conflict_next", PC_NEXT, 32'h18);
    seq_cycle(); #1;
    check("lit_conflict_pc", PC, 32'h18);
    check("lit_conflict_err", {31'd0, RAS_ERR}, 32'd1);
    seq_cycle(); #1;
    check("lit_err_clear", {31'd0, RAS_ERR}, 32'd0);
`else
    check("lit_nocall_next", PC_NEXT, 32'h14);
    seq_cycle(); #1;
    check("lit_nocall_pc", PC, 32'h14);
    check("lit_nocall_empty", {31'd0, RAS_EMPTY}, 32'd1);
`endif

    // Five CALLs with offset 1 word, then five RETs.
    do_reset();
    repeat (5) apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h01, 1'b1, 1'b0);
`ifdef PC_SEQ_RAS_EN
    #1;
    check("lit_call4_pc", PC, 32'h20);
    check("lit_call4_full", {31'd0, RAS_FULL}, 32'd1);
`endif
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h01, 1'b0, 1'b1);
`ifdef PC_SEQ_RAS_EN
    #1;
    check("lit_call5_pc", PC, 32'h28);
    check("lit_call5_err", {31'd0, RAS_ERR}, 32'd1);
    check("lit_ret1_next", PC_NEXT, 32'h24);
`endif
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h01, 1'b0, 1'b1);
`ifdef PC_SEQ_RAS_EN
    #1; check("lit_ret1_pc", PC, 32'h24);
`endif
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h01, 1'b0, 1'b1);
`ifdef PC_SEQ_RAS_EN
    #1; check("lit_ret2_pc", PC, 32'h1C);
`endif
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h01, 1'b0, 1'b1);
`ifdef PC_SEQ_RAS_EN
    #1; check("lit_ret3_pc", PC, 32'h14);
`endif
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h01, 1'b0, 1'b1);
`ifdef PC_SEQ_RAS_EN
    #1;
    check("lit_ret4_pc", PC, 32'hC);
    check("lit_ret4_empty", {31'd0, RAS_EMPTY}, 32'd1);
`endif
    seq_cycle();
`ifdef PC_SEQ_RAS_EN
    #1;
    check("lit_ret5_pc", PC, 32'h10);
    check("lit_ret5_err", {31'd0, RAS_ERR}, 32'd1);
`endif

    // Stall with a jump pending (and RET requested), then reset mid-stall.
    do_reset();
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) apply(1'b0, 1'b1, SEL_JUMP, 1'b0, 8'h03, 1'b0, 1'b1);
    #1;
    check("lit_stall_pc", PC, 32'h4);
    check("lit_stall_empty", {31'd0, RAS_EMPTY}, {31'd0, !RasOn});
    check("lit_stall_err", {31'd0, RAS_ERR}, 32'd0);
    apply(1'b0, 1'b1, SEL_JUMP, 1'b0, 8'h03, 1'b0, 1'b1); #1;
    check("lit_stall_hold", PC, 32'h4);
    apply(1'b1, 1'b1, SEL_JUMP, 1'b0, 8'h03, 1'b0, 1'b1);
    seq_cycle(); #1;
    check("lit_stall_rst_pc", PC, 32'h0);
    check("lit_stall_rst_empty", {31'd0, RAS_EMPTY}, 32'd1);

    // Reset arriving together with a CALL.
    apply(1'b0, 1'b0, SEL_SEQ, 1'b0, 8'h02, 1'b1, 1'b0);
    apply(1'b1, 1'b0, SEL_SEQ, 1'b0, 8'h02, 1'b1, 1'b0);
    seq_cycle(); #1;
    check("lit_callrst_pc", PC, 32'h0);
    check("lit_callrst_empty", {31'd0, RAS_EMPTY}, 32'd1);
    seq_cycle();
    seq_cycle();
    @(negedge CLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
